// File: rtl/risc_ctrl_pkg.sv
// Shared definitions for the Simple RISC Machine controller: FSM state
// encoding, instruction classes, opcode/op field values, memory command codes
// and one-hot bit positions for the writeback and register-field selects.
package risc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST, S_WAIT, S_IF1, S_IF2, S_UPD_PC, S_DECODE, S_WR_IMM,
    S_GET_A, S_GET_B, S_EXEC, S_WR_REG,
    S_ADDR, S_LD_ADDR, S_MEM_RD, S_WR_MEM, S_GET_D, S_EXEC_D, S_MEM_WR,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    INS_MOV_IMM, INS_MOV_REG, INS_ALU, INS_CMP, INS_MVN, INS_LDR, INS_STR
  } ins_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam int VSEL_C      = 0;
  localparam int VSEL_PC     = 1;
  localparam int VSEL_SXIMM8 = 2;
  localparam int VSEL_MDATA  = 3;

  localparam int NSEL_RM = 0;
  localparam int NSEL_RD = 1;
  localparam int NSEL_RN = 2;

  // stop=1 sends DECODE to HALT; legal=0 additionally raises err.
  typedef struct packed {
    logic legal;
    logic stop;
    ins_t ins;
  } dec_t;

  function automatic dec_t decode_ir(input logic [2:0] opcode, input logic [1:0] op);
    dec_t res;
    res.legal = 1'b0;
    res.stop  = 1'b1;
    res.ins   = INS_ALU;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOV_IMM) begin
          res = '{legal: 1'b1, stop: 1'b0, ins: INS_MOV_IMM};
        end else if (op == OP_MOV_REG) begin
          res = '{legal: 1'b1, stop: 1'b0, ins: INS_MOV_REG};
        end
      end
      OPC_ALU: begin
        res.legal = 1'b1;
        res.stop  = 1'b0;
        if (op == OP_CMP)      res.ins = INS_CMP;
        else if (op == OP_MVN) res.ins = INS_MVN;
        else                   res.ins = INS_ALU;
      end
      OPC_LDR:  if (op == OP_MEM) res = '{legal: 1'b1, stop: 1'b0, ins: INS_LDR};
      OPC_STR:  if (op == OP_MEM) res = '{legal: 1'b1, stop: 1'b0, ins: INS_STR};
      OPC_HALT: res.legal = 1'b1;
      default:  res.legal = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state watchdog, shared by every handshake state.
// Ports:
//   clk, reset  clock, asynchronous active-low reset
//   active      controller is in a state waiting on mem_ready
//   ready       memory completes the access this cycle
//   expired     this is the LIMIT-th consecutive not-ready cycle (trap now)
// LIMIT=0 disables the trap.
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  // Down-counter of remaining not-ready cycles; 0 means unarmed, so the first
  // stalled cycle of an access loads LIMIT-1 and terminal count is 1.
  logic [CW-1:0] rem_q, rem_d;

  always_comb begin
    rem_d   = '0;
    expired = 1'b0;
    if (LIMIT != 0 && active && !ready) begin
      if (rem_q == CW'(1) || (rem_q == '0 && LIMIT == 1)) begin
        expired = 1'b1;
      end else if (rem_q == '0) begin
        rem_d = CW'(LIMIT - 1);
      end else begin
        rem_d = rem_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rem_q <= '0;
    else        rem_q <= rem_d;
  end

endmodule

// File: rtl/risc_ctrl_fsm.sv
// Moore sequencing controller for the Simple RISC Machine datapath: fetch,
// decode, ALU/MOV execute, LDR/STR with ready/valid memory, HALT and traps.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   s                           start pulse (AUTO_FETCH=0 only)
//   opcode, op                  IR[15:13], IR[12:11]
//   mem_ready                   memory completes the current mem_cmd
//   loada..loads, asel, bsel    datapath enables / ALU operand selects
//   vsel, nsel, write           writeback mux, register-field select, RF write
//   load_ir, load_pc, reset_pc, addr_sel, load_addr   fetch/address controls
//   mem_cmd                     00 none, 01 read, 10 write
//   w, halted, err              waiting for s, in HALT, sticky trap flag
//
// state     | meaning
// RST       | reset PC
// WAIT      | idle until s (legacy mode)
// IF1/IF2   | instruction read issue / wait for mem_ready, load IR
// UPD_PC    | PC increment
// DECODE    | dispatch on {opcode,op}, latch instruction class
// WR_IMM    | Rn <= sximm8
// GET_A/B   | load A from Rn / B from Rm
// EXEC      | ALU into C (or status for CMP)
// WR_REG    | Rd <= C
// ADDR      | C <= Rn + sximm5
// LD_ADDR   | address register <= C
// MEM_RD    | data read, wait for mem_ready
// WR_MEM    | Rd <= mdata
// GET_D     | B <= Rd (store data)
// EXEC_D    | C <= B
// MEM_WR    | data write, wait for mem_ready
// HALT      | absorbing stop
module risc_ctrl_fsm
  import risc_ctrl_pkg::*;
#(
  parameter int AUTO_FETCH  = 1,
  parameter int VSEL_W      = 4,
  parameter int NSEL_W      = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic [2:0]        opcode,
  input  logic [1:0]        op,
  input  logic              mem_ready,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [VSEL_W-1:0] vsel,
  output logic [NSEL_W-1:0] nsel,
  output logic              write,
  output logic              load_ir,
  output logic              load_pc,
  output logic              reset_pc,
  output logic              addr_sel,
  output logic              load_addr,
  output logic [1:0]        mem_cmd,
  output logic              w,
  output logic              halted,
  output logic              err
);

  localparam state_t END_STATE = (AUTO_FETCH != 0) ? S_IF1 : S_WAIT;

  state_t state_q, state_d;
  ins_t   ins_q, ins_d;
  logic   err_q, err_d;
  logic   in_wait, tmo;
  dec_t   dec;

  assign in_wait = (state_q == S_IF2) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign dec     = decode_ir(opcode, op);

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .active  (in_wait),
    .ready   (mem_ready),
    .expired (tmo)
  );

  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    err_d   = err_q;
    case (state_q)
      S_RST:    state_d = (AUTO_FETCH != 0) ? S_IF1 : S_WAIT;
      S_WAIT:   if (s) state_d = S_DECODE;
      S_IF1:    state_d = S_IF2;
      S_IF2: begin
        if (mem_ready) state_d = S_UPD_PC;
        else if (tmo) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_UPD_PC: state_d = S_DECODE;
      S_DECODE: begin
        ins_d = dec.ins;
        if (dec.stop) begin
          state_d = S_HALT;
          err_d   = err_q | ~dec.legal;
        end else begin
          case (dec.ins)
            INS_MOV_IMM:          state_d = S_WR_IMM;
            INS_MOV_REG, INS_MVN: state_d = S_GET_B;
            default:              state_d = S_GET_A;
          endcase
        end
      end
      S_WR_IMM, S_WR_REG, S_WR_MEM: state_d = END_STATE;
      S_GET_A:   state_d = (ins_q == INS_LDR || ins_q == INS_STR) ? S_ADDR : S_GET_B;
      S_GET_B:   state_d = S_EXEC;
      S_EXEC:    state_d = (ins_q == INS_CMP) ? END_STATE : S_WR_REG;
      S_ADDR:    state_d = S_LD_ADDR;
      S_LD_ADDR: state_d = (ins_q == INS_LDR) ? S_MEM_RD : S_GET_D;
      S_MEM_RD: begin
        if (mem_ready) state_d = S_WR_MEM;
        else if (tmo) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_GET_D:  state_d = S_EXEC_D;
      S_EXEC_D: state_d = S_MEM_WR;
      S_MEM_WR: begin
        if (mem_ready) state_d = END_STATE;
        else if (tmo) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      ins_q   <= INS_ALU;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = '0;
    nsel      = '0;
    write     = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    w         = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_WAIT: w = 1'b1;
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = mem_ready;
      end
      S_UPD_PC: load_pc = 1'b1;
      S_WR_IMM: begin
        nsel[NSEL_RN]     = 1'b1;
        vsel[VSEL_SXIMM8] = 1'b1;
        write             = 1'b1;
      end
      S_GET_A: begin
        nsel[NSEL_RN] = 1'b1;
        loada         = 1'b1;
      end
      S_GET_B: begin
        nsel[NSEL_RM] = 1'b1;
        loadb         = 1'b1;
      end
      S_EXEC: begin
        asel  = (ins_q == INS_MOV_REG) || (ins_q == INS_MVN);
        loadc = (ins_q != INS_CMP);
        loads = (ins_q == INS_CMP);
      end
      S_WR_REG: begin
        nsel[NSEL_RD] = 1'b1;
        vsel[VSEL_C]  = 1'b1;
        write         = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LD_ADDR: load_addr = 1'b1;
      S_MEM_RD:  mem_cmd   = MEM_READ;
      S_WR_MEM: begin
        nsel[NSEL_RD]    = 1'b1;
        vsel[VSEL_MDATA] = 1'b1;
        write            = 1'b1;
      end
      S_GET_D: begin
        nsel[NSEL_RD] = 1'b1;
        loadb         = 1'b1;
      end
      S_EXEC_D: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MEM_WR: mem_cmd = MEM_WRITE;
      S_HALT:   halted  = 1'b1;
      default:  halted  = 1'b0;
    endcase
    err = err_q;
  end

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
module tb_risc_ctrl_fsm;

  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1_n, rst0_n, s, mem_ready;
  logic [2:0] opcode;
  logic [1:0] op;

  logic       loada_1, loadb_1, loadc_1, loads_1, asel_1, bsel_1, write_1;
  logic       load_ir_1, load_pc_1, reset_pc_1, addr_sel_1, load_addr_1, w_1, halted_1, err_1;
  logic [3:0] vsel_1;
  logic [2:0] nsel_1;
  logic [1:0] mem_cmd_1;

  logic       loada_0, loadb_0, loadc_0, loads_0, asel_0, bsel_0, write_0;
  logic       load_ir_0, load_pc_0, reset_pc_0, addr_sel_0, load_addr_0, w_0, halted_0, err_0;
  logic [3:0] vsel_0;
  logic [2:0] nsel_0;
  logic [1:0] mem_cmd_0;

  risc_ctrl_fsm #(.AUTO_FETCH(1), .VSEL_W(4), .NSEL_W(3), .MEM_TIMEOUT(TMO)) dut1 (
    .clk(clk), .reset(rst1_n), .s(s), .opcode(opcode), .op(op), .mem_ready(mem_ready),
    .loada(loada_1), .loadb(loadb_1), .loadc(loadc_1), .loads(loads_1),
    .asel(asel_1), .bsel(bsel_1), .vsel(vsel_1), .nsel(nsel_1), .write(write_1),
    .load_ir(load_ir_1), .load_pc(load_pc_1), .reset_pc(reset_pc_1), .addr_sel(addr_sel_1),
    .load_addr(load_addr_1), .mem_cmd(mem_cmd_1), .w(w_1), .halted(halted_1), .err(err_1)
  );

  risc_ctrl_fsm #(.AUTO_FETCH(0), .VSEL_W(4), .NSEL_W(3), .MEM_TIMEOUT(TMO)) dut0 (
    .clk(clk), .reset(rst0_n), .s(s), .opcode(opcode), .op(op), .mem_ready(mem_ready),
    .loada(loada_0), .loadb(loadb_0), .loadc(loadc_0), .loads(loads_0),
    .asel(asel_0), .bsel(bsel_0), .vsel(vsel_0), .nsel(nsel_0), .write(write_0),
    .load_ir(load_ir_0), .load_pc(load_pc_0), .reset_pc(reset_pc_0), .addr_sel(addr_sel_0),
    .load_addr(load_addr_0), .mem_cmd(mem_cmd_0), .w(w_0), .halted(halted_0), .err(err_0)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       loada, loadb, loadc, loads, asel, bsel, write, load_addr;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic [1:0] mem_cmd;
  } obs_t;

  obs_t tr[$];

  function automatic obs_t grab1();
    obs_t t;
    t.loada = loada_1; t.loadb = loadb_1; t.loadc = loadc_1; t.loads = loads_1;
    t.asel = asel_1; t.bsel = bsel_1; t.write = write_1; t.load_addr = load_addr_1;
    t.nsel = nsel_1; t.vsel = vsel_1; t.mem_cmd = mem_cmd_1;
    return t;
  endfunction

  // Called at a negedge with dut1 in IF1; runs until the next IF1 or HALT.
  // fw/dw: not-ready cycles for the instruction fetch and the data access.
  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input int fw, input int dw,
                           output int cyc, output int nwr, output int nlc, output int nls,
                           output int dcmd);
    int   frem, drem;
    logic prev_as;
    frem = fw; drem = dw; prev_as = 1'b1;
    opcode = opc; op = o;
    cyc = 0; nwr = 0; nlc = 0; nls = 0; dcmd = 0;
    tr.delete();
    for (int k = 0; k < 300; k++) begin
      if (halted_1) return;
      if (cyc > 0 && addr_sel_1 && !prev_as) return;
      tr.push_back(grab1());
      cyc++;
      nwr += int'(write_1);
      nlc += int'(loadc_1);
      nls += int'(loads_1);
      mem_ready = 1'b0;
      if (mem_cmd_1 != 2'b00) begin
        if (addr_sel_1) begin
          if (cyc > 1) begin
            if (frem == 0) mem_ready = 1'b1;
            else frem--;
          end
        end else begin
          dcmd++;
          if (drem == 0) mem_ready = 1'b1;
          else drem--;
        end
      end
      prev_as = addr_sel_1;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL run_instr_budget: opcode=%0d op=%0d no IF1/HALT within 300 cycles", opc, o);
  endtask

  // Instruction-level reference: cycle counts and control-pulse counts per
  // instruction class, plus wait and timeout arithmetic.
  task automatic model(input logic [2:0] opc, input logic [1:0] o, input int fw, input int dw,
                       output int cyc, output int nwr, output int nlc, output int nls,
                       output bit hlt, output bit er);
    int lat, pre, lc_trap;
    bit mem, stop, legal;
    lat = 0; pre = 0; lc_trap = 0; mem = 0; stop = 0; legal = 1;
    nwr = 0; nlc = 0; nls = 0;
    casez ({opc, o})
      5'b11010: begin lat = 5; nwr = 1; end
      5'b11000: begin lat = 7; nwr = 1; nlc = 1; end
      5'b10101: begin lat = 7; nls = 1; end
      5'b10111: begin lat = 7; nwr = 1; nlc = 1; end
      5'b101??: begin lat = 8; nwr = 1; nlc = 1; end
      5'b01100: begin lat = 9; nwr = 1; nlc = 1; mem = 1; pre = 7; lc_trap = 1; end
      5'b10000: begin lat = 10; nlc = 2; mem = 1; pre = 9; lc_trap = 2; end
      5'b111??: stop = 1;
      default:  begin stop = 1; legal = 0; end
    endcase
    if (fw >= TMO) begin
      cyc = 1 + TMO; nwr = 0; nlc = 0; nls = 0; hlt = 1; er = 1;
    end else if (stop) begin
      cyc = 4 + fw; nwr = 0; nlc = 0; nls = 0; hlt = 1; er = !legal;
    end else if (mem && dw >= TMO) begin
      cyc = pre + fw + TMO; nwr = 0; nlc = lc_trap; nls = 0; hlt = 1; er = 1;
    end else begin
      cyc = lat + fw + (mem ? dw : 0); hlt = 0; er = 0;
    end
  endtask

  task automatic reset1();
    @(negedge clk);
    rst1_n = 1'b0;
    @(negedge clk);
    rst1_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] opc;
    logic [1:0] o;
    int         cyc, wr, lc, ls;
    bit         hlt, er;
  } vec_t;

  vec_t vt[10];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc, nwr, nlc, nls, dcmd, ecyc, ewr, elc, els;
    bit  ehlt, eerr;
    logic [4:0] enc[14];
    int  idx, fw, dw, r;

    vt[0] = '{3'b110, 2'b10, 5, 1, 0, 0, 0, 0};
    vt[1] = '{3'b110, 2'b00, 7, 1, 1, 0, 0, 0};
    vt[2] = '{3'b101, 2'b00, 8, 1, 1, 0, 0, 0};
    vt[3] = '{3'b101, 2'b01, 7, 0, 0, 1, 0, 0};
    vt[4] = '{3'b101, 2'b10, 8, 1, 1, 0, 0, 0};
    vt[5] = '{3'b101, 2'b11, 7, 1, 1, 0, 0, 0};
    vt[6] = '{3'b011, 2'b00, 9, 1, 1, 0, 0, 0};
    vt[7] = '{3'b100, 2'b00, 10, 0, 2, 0, 0, 0};
    vt[8] = '{3'b111, 2'b01, 4, 0, 0, 0, 1, 0};
    vt[9] = '{3'b001, 2'b00, 4, 0, 0, 0, 1, 1};

    enc[0] = 5'b11010; enc[1] = 5'b11000; enc[2] = 5'b10100; enc[3] = 5'b10101;
    enc[4] = 5'b10110; enc[5] = 5'b10111; enc[6] = 5'b01100; enc[7] = 5'b10000;
    enc[8] = 5'b11101; enc[9] = 5'b00100; enc[10] = 5'b01101; enc[11] = 5'b11001;
    enc[12] = 5'b10001; enc[13] = 5'b01000;

    rst1_n = 1'b0; rst0_n = 1'b0; s = 1'b0; mem_ready = 1'b0;
    opcode = 3'b000; op = 2'b00;
    #1;
    chk("rst_reset_pc", reset_pc_1, 1);
    chk("rst_load_pc", load_pc_1, 1);
    chk("rst_mem_cmd", mem_cmd_1, 0);
    chk("rst_addr_sel", addr_sel_1, 0);
    chk("rst_write", write_1, 0);
    chk("rst_err", err_1, 0);
    chk("rst_halted", halted_1, 0);
    chk("rst0_w", w_0, 0);

    @(negedge clk);
    rst1_n = 1'b1;
    @(negedge clk);
    chk("first_if1_addr_sel", addr_sel_1, 1);
    chk("first_if1_mem_cmd", mem_cmd_1, 1);

    // zero-wait table
    for (int i = 0; i < 10; i++) begin
      run_instr(vt[i].opc, vt[i].o, 0, 0, cyc, nwr, nlc, nls, dcmd);
      chk($sformatf("vec%0d_cycles", i), cyc, vt[i].cyc);
      chk($sformatf("vec%0d_writes", i), nwr, vt[i].wr);
      chk($sformatf("vec%0d_loadc", i), nlc, vt[i].lc);
      chk($sformatf("vec%0d_loads", i), nls, vt[i].ls);
      chk($sformatf("vec%0d_halted", i), halted_1, vt[i].hlt);
      chk($sformatf("vec%0d_err", i), err_1, vt[i].er);
      if (halted_1) reset1();
    end

    // ADD step by step
    run_instr(3'b101, 2'b00, 0, 0, cyc, nwr, nlc, nls, dcmd);
    chk("add_cycles", cyc, 8);
    chk("add_geta", {tr[4].loada, tr[4].nsel}, {1'b1, 3'b100});
    chk("add_getb", {tr[5].loadb, tr[5].nsel}, {1'b1, 3'b001});
    chk("add_exec", {tr[6].loadc, tr[6].loads, tr[6].asel}, 3'b100);
    chk("add_wr", {tr[7].write, tr[7].nsel, tr[7].vsel}, {1'b1, 3'b010, 4'b0001});

    // CMP
    run_instr(3'b101, 2'b01, 0, 0, cyc, nwr, nlc, nls, dcmd);
    chk("cmp_exec", {tr[6].loads, tr[6].loadc}, 2'b10);
    chk("cmp_nowrite", nwr, 0);

    // MOV reg asel in EXEC
    run_instr(3'b110, 2'b00, 0, 0, cyc, nwr, nlc, nls, dcmd);
    chk("movr_exec_asel", {tr[5].asel, tr[5].loadc}, 2'b11);

    // LDR with 3 stall cycles
    run_instr(3'b011, 2'b00, 0, 3, cyc, nwr, nlc, nls, dcmd);
    chk("ldr_cmd_cycles", dcmd, 4);
    chk("ldr_addr", {tr[5].bsel, tr[5].loadc}, 2'b11);
    chk("ldr_ld_addr", tr[6].load_addr, 1);
    chk("ldr_cmd_held", tr[10].mem_cmd, 2'b01);
    chk("ldr_wrmem", {tr[11].write, tr[11].nsel, tr[11].vsel}, {1'b1, 3'b010, 4'b1000});
    chk("ldr_cycles", cyc, 12);
    chk("ldr_err", err_1, 0);

    // STR
    run_instr(3'b100, 2'b00, 0, 0, cyc, nwr, nlc, nls, dcmd);
    chk("str_getd", {tr[7].loadb, tr[7].nsel}, {1'b1, 3'b010});
    chk("str_execd", {tr[8].asel, tr[8].loadc}, 2'b11);
    chk("str_memwr", tr[9].mem_cmd, 2'b10);

    // fetch stalled 14 cycles: ready on the limit cycle wins
    run_instr(3'b110, 2'b10, 14, 0, cyc, nwr, nlc, nls, dcmd);
    chk("fetch14_cycles", cyc, 19);
    chk("fetch14_halted", halted_1, 0);
    chk("fetch14_err", err_1, 0);

    // fetch stalled forever: trap
    run_instr(3'b110, 2'b10, 1000, 0, cyc, nwr, nlc, nls, dcmd);
    chk("tmo_cycles", cyc, 16);
    chk("tmo_halted", halted_1, 1);
    chk("tmo_err", err_1, 1);
    repeat (3) @(negedge clk);
    chk("tmo_absorb", {halted_1, err_1}, 2'b11);
    reset1();
    chk("tmo_reset_err", err_1, 0);

    // reset during MEM_RD
    opcode = 3'b011; op = 2'b00;
    for (int k = 0; k < 40; k++) begin
      if (mem_cmd_1 == 2'b01 && !addr_sel_1) break;
      mem_ready = 1'b1;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    chk("memrd_cmd_before", {addr_sel_1, mem_cmd_1}, 3'b001);
    #2 rst1_n = 1'b0;
    #1;
    chk("memrd_reset_cmd", mem_cmd_1, 0);
    chk("memrd_reset_pc", {reset_pc_1, load_pc_1}, 2'b11);
    @(negedge clk);
    rst1_n = 1'b1;
    #1;
    chk("memrd_rst_state", reset_pc_1, 1);
    @(negedge clk);
    chk("memrd_after_if1", {addr_sel_1, mem_cmd_1}, 3'b101);

    // randomized against the model
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 13);
      r = $urandom_range(0, 9);
      fw = (r < 7) ? $urandom_range(0, 3) : ((r == 7) ? 14 : ((r == 8) ? 15 : 16));
      r = $urandom_range(0, 9);
      dw = (r < 7) ? $urandom_range(0, 3) : ((r == 7) ? 14 : ((r == 8) ? 15 : 20));
      model(enc[idx][4:2], enc[idx][1:0], fw, dw, ecyc, ewr, elc, els, ehlt, eerr);
      run_instr(enc[idx][4:2], enc[idx][1:0], fw, dw, cyc, nwr, nlc, nls, dcmd);
      chk($sformatf("rnd%0d_cycles(enc=%b fw=%0d dw=%0d)", i, enc[idx], fw, dw), cyc, ecyc);
      chk($sformatf("rnd%0d_writes", i), nwr, ewr);
      chk($sformatf("rnd%0d_loadc", i), nlc, elc);
      chk($sformatf("rnd%0d_loads", i), nls, els);
      chk($sformatf("rnd%0d_halted", i), halted_1, ehlt);
      chk($sformatf("rnd%0d_err", i), err_1, eerr);
      if (halted_1) reset1();
    end

    // legacy start-pulse mode
    @(negedge clk);
    rst0_n = 1'b1;
    @(negedge clk);
    chk("af0_wait_w", w_0, 1);
    repeat (2) @(negedge clk);
    chk("af0_wait_stays", {w_0, write_0, mem_cmd_0}, 4'b1000);
    opcode = 3'b110; op = 2'b10; s = 1'b1;
    @(negedge clk);
    s = 1'b0;
    chk("af0_decode_w", w_0, 0);
    @(negedge clk);
    chk("af0_wrimm", {write_0, nsel_0, vsel_0}, {1'b1, 3'b100, 4'b0100});
    @(negedge clk);
    chk("af0_back_wait", w_0, 1);
    opcode = 3'b001; op = 2'b00; s = 1'b1;
    @(negedge clk);
    s = 1'b0;
    @(negedge clk);
    chk("af0_ill_halt", {halted_0, err_0}, 2'b11);
    for (int k = 0; k < 3; k++) begin
      s = 1'b1;
      @(negedge clk);
      s = 1'b0;
      @(negedge clk);
    end
    chk("af0_ill_absorb", {halted_0, err_0, w_0}, 3'b110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
